// File: rtl/crc_arb_pkg.sv
// Shared types for the CRC-8 engine arbiter: FSM states, error causes and a
// saturating counter helper.
package crc_arb_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        BUSY   = 3'd2,
        SETTLE = 3'd3,
        RESP   = 3'd4
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/crc_arbiter_if.sv
// Requester-side request/response bundle of the CRC arbiter; master is the
// requester side, slave is the arbiter.
interface crc_arbiter_if #(
    parameter int NREQ = 2,
    parameter int MAXB = 6
);
    localparam int LW = $clog2(MAXB + 1);

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*8*MAXB-1:0] req_data;
    logic [NREQ*LW-1:0]     req_len;
    logic [NREQ-1:0]        resp_valid;
    logic [NREQ-1:0]        resp_ready;
    logic [7:0]             resp_crc;
    logic                   resp_err;
    logic [7:0]             err_count;

    modport master (
        output req_valid, req_data, req_len, resp_ready,
        input  req_ready, resp_valid, resp_crc, resp_err, err_count
    );

    modport slave (
        input  req_valid, req_data, req_len, resp_ready,
        output req_ready, resp_valid, resp_crc, resp_err, err_count
    );

endinterface

// File: rtl/crc_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request bit after 'last', with wrap.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        // Offset N wraps back to 'last' itself, so a lone requester can win again.
        for (int off = 1; off <= N; off++) begin
            if (!any && req[(int'(last) + off) % N]) begin
                any = 1'b1;
                idx = IW'((int'(last) + off) % N);
                onehot[(int'(last) + off) % N] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/crc_arbiter.sv
// Time-multiplexes one CRC-8 engine between NREQ requesters with round-robin
// grants, length checking, a BUSY watchdog and a saturating error counter.
module crc_arbiter
    import crc_arb_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int MAXB    = 6,
    parameter int TIMEOUT = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    crc_arbiter_if.slave                 bus,
    output logic                         eng_start,
    output logic [$clog2(MAXB+1)-1:0]    eng_len,
    output logic [8*MAXB-1:0]            eng_bytes_flat,
    input  logic                         eng_done,
    input  logic [7:0]                   eng_crc
);

    localparam int LW = $clog2(MAXB + 1);
    localparam int IW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT);
    localparam int DW = 8 * MAXB;

    state_t          state, state_nxt;
    logic [IW-1:0]   last_grant, gidx;
    logic [NREQ-1:0] pick_onehot;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic [DW-1:0]   pick_data, hold_data;
    logic [LW-1:0]   pick_len, hold_len;
    logic            len_ok;
    logic [TW-1:0]   timer;
    logic            timer_expired;
    logic [NREQ-1:0] grant_onehot;
    logic [NREQ-1:0] resp_valid;
    logic [7:0]      resp_crc, err_count;
    logic [1:0]      err_code;

    rr_pick #(.N(NREQ), .IW(IW)) u_pick (
        .req    (bus.req_valid),
        .last   (last_grant),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign pick_data     = bus.req_data[pick_idx*DW +: DW];
    assign pick_len      = bus.req_len[pick_idx*LW +: LW];
    assign len_ok        = (pick_len != '0) && (pick_len <= LW'(MAXB));
    assign timer_expired = (timer == TW'(TIMEOUT - 1));
    assign grant_onehot  = NREQ'(1) << gidx;

    assign bus.req_ready  = (state == IDLE) ? pick_onehot : '0;
    assign bus.resp_valid = resp_valid;
    assign bus.resp_crc   = resp_crc;
    assign bus.resp_err   = (err_code != ERR_NONE);
    assign bus.err_count  = err_count;
    assign eng_len        = hold_len;
    assign eng_bytes_flat = hold_data;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_any) state_nxt = len_ok ? START : RESP;
            START:   state_nxt = BUSY;
            // A done pulse wins over a watchdog expiry in the same cycle.
            BUSY:    if (eng_done) state_nxt = SETTLE;
                     else if (timer_expired) state_nxt = RESP;
            SETTLE:  state_nxt = RESP;
            RESP:    if (bus.resp_ready[gidx]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= IW'(NREQ - 1);
            gidx       <= '0;
            hold_data  <= '0;
            hold_len   <= '0;
            timer      <= '0;
            eng_start  <= 1'b0;
            resp_valid <= '0;
            resp_crc   <= 8'h00;
            err_code   <= ERR_NONE;
            err_count  <= 8'h00;
        end else begin
            eng_start <= 1'b0;
            case (state)
                IDLE: if (pick_any) begin
                    gidx      <= pick_idx;
                    hold_data <= pick_data;
                    hold_len  <= pick_len;
                    if (len_ok) begin
                        eng_start <= 1'b1;
                    end else begin
                        resp_valid <= pick_onehot;
                        resp_crc   <= 8'h00;
                        err_code   <= ERR_LEN;
                        err_count  <= sat_inc8(err_count);
                    end
                end
                START: timer <= '0;
                BUSY: if (!eng_done) begin
                    if (timer_expired) begin
                        resp_valid <= grant_onehot;
                        resp_crc   <= 8'h00;
                        err_code   <= ERR_TIMEOUT;
                        err_count  <= sat_inc8(err_count);
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                // eng_crc is only valid the cycle after eng_done.
                SETTLE: begin
                    resp_valid <= grant_onehot;
                    resp_crc   <= eng_crc;
                    err_code   <= ERR_NONE;
                end
                RESP: if (bus.resp_ready[gidx]) begin
                    resp_valid <= '0;
                    last_grant <= gidx;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_arbiter.sv
// Bench for crc_arbiter: engine stub, directed vector table, randomized jobs
// against a round-robin/latency reference model, and a mid-job reset sequence.
module tb_crc_arbiter;

    localparam int NREQ    = 2;
    localparam int MAXB    = 6;
    localparam int TIMEOUT = 64;
    localparam int LW      = $clog2(MAXB + 1);
    localparam int DW      = 8 * MAXB;

    logic            clk = 1'b0;
    logic            rst;
    logic            eng_start;
    logic [LW-1:0]   eng_len;
    logic [DW-1:0]   eng_bytes;
    logic            eng_done;
    logic [7:0]      eng_crc;

    // Engine stub: done pulse arrives k+1 cycles after the eng_start cycle, and
    // the result is driven only in the cycle after done (junk value otherwise).
    logic            stub_pulse = 1'b0;
    logic            done_d     = 1'b0;
    logic            inject     = 1'b0;
    logic [7:0]      crc_val    = 8'hA5;
    int              stub_k     = 0;
    int              stub_cnt   = 0;
    int              cyc        = 0;

    int checks = 0;
    int errors = 0;
    int m_last = NREQ - 1;
    int m_ecnt = 0;

    crc_arbiter_if #(.NREQ(NREQ), .MAXB(MAXB)) bus ();

    crc_arbiter #(.NREQ(NREQ), .MAXB(MAXB), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus.slave),
        .eng_start      (eng_start),
        .eng_len        (eng_len),
        .eng_bytes_flat (eng_bytes),
        .eng_done       (eng_done),
        .eng_crc        (eng_crc)
    );

    always #5 clk = ~clk;

    assign eng_done = stub_pulse | inject;
    assign eng_crc  = done_d ? crc_val : 8'h3C;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        done_d <= eng_done;
        if (rst) begin
            stub_cnt   <= 0;
            stub_pulse <= 1'b0;
        end else begin
            stub_pulse <= (stub_cnt == 1);
            if (eng_start && stub_k > 0) stub_cnt <= stub_k;
            else if (stub_cnt > 0)       stub_cnt <= stub_cnt - 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [NREQ-1:0] oh(input int i);
        logic [NREQ-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Reference: scan requesters last+1, last+2, ... with wrap; first pending wins.
    function automatic int model_pick(input logic [NREQ-1:0] v, input int last);
        for (int off = 1; off <= NREQ; off++)
            if (v[(last + off) % NREQ]) return (last + off) % NREQ;
        return -1;
    endfunction

    task automatic run_job(input logic [NREQ-1:0] v, input logic [NREQ*LW-1:0] lens,
                           input int k, input int stall, input bit inj,
                           input int exp_g, input bit exp_err, input int exp_lat,
                           input int exp_ecnt, input logic [7:0] cv);
        logic [NREQ*DW-1:0] d;
        logic [7:0]         exp_crc;
        logic [NREQ-1:0]    rv_snap;
        logic [7:0]         crc_snap;
        logic               err_snap;
        bit                 got, extra_grant, stable;
        int                 gcyc, starts;

        exp_crc = exp_err ? 8'h00 : cv;
        if (inj) begin
            // Stale done while idle must not disturb the next job.
            bus.req_valid = '0;
            inject = 1'b1;
            @(posedge clk); #1;
            inject = 1'b0;
            @(posedge clk); #1;
        end
        for (int b = 0; b < NREQ * DW; b++) d[b] = 1'($urandom_range(1, 0));
        crc_val       = cv;
        stub_k        = k;
        bus.req_data  = d;
        bus.req_len   = lens;
        bus.req_valid = v;

        got = 0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (bus.req_ready != '0) got = 1;
        end
        check("grant_seen", 64'(got), 64'd1);
        gcyc = cyc;
        check("grant", 64'(bus.req_ready), 64'(oh(exp_g)));

        got = 0; extra_grant = 0; starts = 0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if (eng_start) begin
                starts++;
                check("eng_len", 64'(eng_len), 64'(lens[exp_g*LW +: LW]));
                check("eng_bytes", 64'(eng_bytes), 64'(d[exp_g*DW +: DW]));
            end
            if (bus.req_ready != '0) extra_grant = 1;
            if (bus.resp_valid != '0) got = 1;
        end
        check("resp_seen", 64'(got), 64'd1);
        check("latency", 64'(cyc - gcyc), 64'(exp_lat));
        check("resp_valid", 64'(bus.resp_valid), 64'(oh(exp_g)));
        check("resp_crc", 64'(bus.resp_crc), 64'(exp_crc));
        check("resp_err", 64'(bus.resp_err), 64'(exp_err));
        check("err_count", 64'(bus.err_count), 64'(exp_ecnt));
        check("eng_starts", 64'(starts), 64'((exp_lat == 1) ? 0 : 1));
        check("no_grant_while_busy", 64'(extra_grant), 64'd0);

        if (stall > 0) begin
            // Ready on the other requesters' bits must be ignored.
            rv_snap = bus.resp_valid; crc_snap = bus.resp_crc; err_snap = bus.resp_err;
            bus.resp_ready = ~oh(exp_g);
            stable = 1;
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                if (bus.resp_valid !== rv_snap || bus.resp_crc !== crc_snap ||
                    bus.resp_err !== err_snap || bus.req_ready !== '0) stable = 0;
            end
            check("stall_stable", 64'(stable), 64'd1);
        end

        bus.resp_ready = oh(exp_g);
        @(posedge clk); #1;
        bus.resp_ready = '0;
        bus.req_valid  = '0;
        check("resp_drop", 64'(bus.resp_valid), 64'd0);
        m_last = exp_g;
    endtask

    typedef struct {
        logic [NREQ-1:0]    valid;
        logic [NREQ*LW-1:0] lens;   // {len1, len0}
        int                 k;      // 0 = engine never answers
        int                 stall;
        bit                 inj;
        int                 g;
        bit                 err;
        int                 lat;    // grant cycle to resp_valid cycle
        int                 ecnt;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [NREQ-1:0]    v;
        logic [NREQ*LW-1:0] lens;
        int                 g, k, len;
        bit                 err;

        // Timeout row: BUSY lasts TIMEOUT cycles after the eng_start cycle.
        tbl[0] = '{2'b11, {3'd5, 3'd4}, 1, 0,  0, 0, 0, 5,           0};
        tbl[1] = '{2'b11, {3'd5, 3'd4}, 2, 0,  0, 1, 0, 6,           0};
        tbl[2] = '{2'b11, {3'd5, 3'd4}, 5, 0,  0, 0, 0, 9,           0};
        tbl[3] = '{2'b11, {3'd5, 3'd4}, 3, 0,  0, 1, 0, 7,           0};
        tbl[4] = '{2'b01, {3'd0, 3'd6}, 3, 0,  0, 0, 0, 7,           0};
        tbl[5] = '{2'b10, {3'd0, 3'd6}, 1, 0,  0, 1, 1, 1,           1};
        tbl[6] = '{2'b01, {3'd2, 3'd7}, 1, 0,  0, 0, 1, 1,           2};
        tbl[7] = '{2'b10, {3'd2, 3'd7}, 1, 10, 0, 1, 0, 5,           2};
        tbl[8] = '{2'b01, {3'd2, 3'd3}, 0, 0,  0, 0, 1, TIMEOUT + 2, 3};
        tbl[9] = '{2'b11, {3'd1, 3'd5}, 3, 0,  1, 1, 0, 7,           3};

        rst = 1'b1;
        bus.req_valid = '0; bus.req_data = '0; bus.req_len = '0; bus.resp_ready = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_err_count", 64'(bus.err_count), 64'd0);
        check("rst_eng_start", 64'(eng_start), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++)
            run_job(tbl[i].valid, tbl[i].lens, tbl[i].k, tbl[i].stall, tbl[i].inj,
                    tbl[i].g, tbl[i].err, tbl[i].lat, tbl[i].ecnt, 8'hA5);
        m_ecnt = 3;

        for (int i = 0; i < 30; i++) begin
            v    = NREQ'($urandom_range(3, 1));
            lens = {3'($urandom_range(7, 0)), 3'($urandom_range(7, 0))};
            k    = $urandom_range(8, 1);
            g    = model_pick(v, m_last);
            len  = int'(lens[g*LW +: LW]);
            err  = (len == 0) || (len > MAXB);
            if (err && m_ecnt < 255) m_ecnt++;
            run_job(v, lens, k, $urandom_range(3, 0), 0, g, err, err ? 1 : k + 4,
                    m_ecnt, 8'($urandom));
        end

        // Reset while the engine is busy: silent abort, state back to power-on.
        bus.req_len   = {3'd4, 3'd4};
        bus.req_valid = 2'b10;
        stub_k        = 30;
        begin
            bit seen;
            seen = 0;
            for (int n = 0; n < 20 && !seen; n++) begin
                @(negedge clk);
                if (eng_start) seen = 1;
            end
            check("rst_job_started", 64'(seen), 64'd1);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        bus.req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("midrst_resp_crc", 64'(bus.resp_crc), 64'd0);
        check("midrst_resp_err", 64'(bus.resp_err), 64'd0);
        check("midrst_err_count", 64'(bus.err_count), 64'd0);
        check("midrst_eng_start", 64'(eng_start), 64'd0);
        check("midrst_eng_len", 64'(eng_len), 64'd0);
        check("midrst_eng_bytes", 64'(eng_bytes), 64'd0);
        check("midrst_req_ready", 64'(bus.req_ready), 64'd0);
        m_last = NREQ - 1;
        m_ecnt = 0;
        run_job(2'b11, {3'd2, 3'd3}, 2, 0, 0, 0, 0, 6, 0, 8'h5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
